// File: rtl/rr_stream_arbiter.sv
// rr_stream_arbiter
// Shares one downstream valid/ready stream sink between N_REQ requester
// streams. The arbiter is round-robin and locks on packets. A requester
// that wins arbitration owns the sink until it completes a beat with
// last=1. The arbiter also counts completed packets.
//
// Handshake: a beat moves on a rising edge where valid and ready are both
// high on the same channel. The valid signal never depends on ready.
// Ready is forwarded combinationally from the sink to the owner only.
// Requesters must hold their data and last stable while valid is high and
// ready is low.
module rr_stream_arbiter #(
    parameter int N_REQ  = 4,
    parameter int DATA_W = 32,
    parameter int CNT_W  = 16
) (
    input  logic                    i_clk,
    input  logic                    i_rst_n,
    input  logic [N_REQ-1:0]        i_valid,
    input  logic [N_REQ*DATA_W-1:0] i_data,
    input  logic [N_REQ-1:0]        i_last,
    output logic [N_REQ-1:0]        o_ready,
    output logic                    o_valid,
    output logic [DATA_W-1:0]       o_data,
    output logic                    o_last,
    input  logic                    i_ready,
    output logic [N_REQ-1:0]        o_grant,
    output logic                    o_busy,
    output logic [CNT_W-1:0]        o_pkt_cnt
);

    // Index width. It is kept at least 1 bit so that N_REQ=1 still
    // elaborates.
    localparam int IDX_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;

    typedef enum logic {
        ST_IDLE   = 1'b0,
        ST_LOCKED = 1'b1
    } state_e;

    state_e             state_q, state_d;
    logic [IDX_W-1:0]   rr_ptr_q, rr_ptr_d;
    logic [IDX_W-1:0]   owner_q, owner_d;
    logic [N_REQ-1:0]   grant_q, grant_d;
    logic [CNT_W-1:0]   pkt_cnt_q, pkt_cnt_d;

    // Arbitration search results.
    logic               req_found;
    logic [IDX_W-1:0]   req_idx;
    logic [IDX_W:0]     cand;

    // Events of the current cycle.
    logic               beat_xfer;
    logic               pkt_done;
    logic [IDX_W-1:0]   owner_next;

    // Round-robin search: the first valid requester starting at rr_ptr,
    // wrapping modulo N_REQ.
    always_comb begin
        req_found = 1'b0;
        req_idx   = '0;
        cand      = '0;
        for (int i = 0; i < N_REQ; i++) begin
            cand = {1'b0, rr_ptr_q} + (IDX_W+1)'(i);
            if (cand >= (IDX_W+1)'(N_REQ)) begin
                cand = cand - (IDX_W+1)'(N_REQ);
            end
            if (!req_found && i_valid[cand[IDX_W-1:0]]) begin
                req_found = 1'b1;
                req_idx   = cand[IDX_W-1:0];
            end
        end
    end

    // Sink-side pass-through from the owning requester. The one-hot grant
    // selects the owner, so a non-owner cannot reach the sink.
    always_comb begin
        o_valid = 1'b0;
        o_data  = '0;
        o_last  = 1'b0;
        o_ready = '0;
        if (state_q == ST_LOCKED) begin
            for (int k = 0; k < N_REQ; k++) begin
                if (grant_q[k]) begin
                    o_valid    = i_valid[k];
                    o_data     = i_data[k*DATA_W +: DATA_W];
                    o_last     = i_last[k];
                    o_ready[k] = i_ready;
                end
            end
        end
    end

    // Beat transfer and end-of-packet detection.
    always_comb begin
        beat_xfer = o_valid && i_ready;
        pkt_done  = beat_xfer && o_last;
    end

    // Round-robin successor of the current owner.
    always_comb begin
        if (owner_q == IDX_W'(N_REQ - 1)) begin
            owner_next = '0;
        end else begin
            owner_next = owner_q + IDX_W'(1);
        end
    end

    // Next-state logic. IDLE spends one cycle arbitrating. LOCKED holds the
    // owner until it completes a last beat. Nothing preempts LOCKED and it
    // has no timeout.
    always_comb begin
        state_d   = state_q;
        rr_ptr_d  = rr_ptr_q;
        owner_d   = owner_q;
        grant_d   = grant_q;
        pkt_cnt_d = pkt_cnt_q;
        case (state_q)
            ST_IDLE: begin
                if (req_found) begin
                    state_d = ST_LOCKED;
                    owner_d = req_idx;
                    for (int k = 0; k < N_REQ; k++) begin
                        grant_d[k] = (IDX_W'(k) == req_idx);
                    end
                end
            end
            ST_LOCKED: begin
                if (pkt_done) begin
                    state_d   = ST_IDLE;
                    grant_d   = '0;
                    rr_ptr_d  = owner_next;
                    pkt_cnt_d = pkt_cnt_q + CNT_W'(1);
                end
            end
            default: begin
                state_d = ST_IDLE;
                grant_d = '0;
            end
        endcase
    end

    // State registers. A reset aborts any packet in flight. The aborted
    // packet is not counted, and the search restarts at index 0.
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            state_q   <= ST_IDLE;
            rr_ptr_q  <= '0;
            owner_q   <= '0;
            grant_q   <= '0;
            pkt_cnt_q <= '0;
        end else begin
            state_q   <= state_d;
            rr_ptr_q  <= rr_ptr_d;
            owner_q   <= owner_d;
            grant_q   <= grant_d;
            pkt_cnt_q <= pkt_cnt_d;
        end
    end

    // Status outputs. o_busy exposes the FSM state directly.
    always_comb begin
        o_grant   = grant_q;
        o_busy    = (state_q == ST_LOCKED);
        o_pkt_cnt = pkt_cnt_q;
    end

endmodule

// File: tb/tb_rr_stream_arbiter.sv
// Testbench for rr_stream_arbiter: directed scenarios, a behavioural
// reference model, an expected-beat scoreboard, and a narrow-counter
// single-requester instance used to exercise counter wrap.
`timescale 1ns/1ps
module tb_rr_stream_arbiter;

    localparam int N  = 4;
    localparam int DW = 32;
    localparam int CW = 16;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    // ---------------- main DUT ----------------
    logic [N-1:0]    req_valid;
    logic [N*DW-1:0] req_data;
    logic [N-1:0]    req_last;
    logic [N-1:0]    req_ready;
    logic            snk_valid;
    logic [DW-1:0]   snk_data;
    logic            snk_last;
    logic            snk_ready;
    logic [N-1:0]    grant;
    logic            busy;
    logic [CW-1:0]   pkt_cnt;

    rr_stream_arbiter #(.N_REQ(N), .DATA_W(DW), .CNT_W(CW)) dut (
        .i_clk     (clk),
        .i_rst_n   (rst_n),
        .i_valid   (req_valid),
        .i_data    (req_data),
        .i_last    (req_last),
        .o_ready   (req_ready),
        .o_valid   (snk_valid),
        .o_data    (snk_data),
        .o_last    (snk_last),
        .i_ready   (snk_ready),
        .o_grant   (grant),
        .o_busy    (busy),
        .o_pkt_cnt (pkt_cnt)
    );

    // ---------------- single-requester DUT, 3-bit counter ----------------
    logic       v1, l1, rdy1, r1, ov1, ol1, busy1;
    logic [31:0] d1, od1;
    logic [0:0] g1;
    logic [2:0] cnt1;

    rr_stream_arbiter #(.N_REQ(1), .DATA_W(32), .CNT_W(3)) dut1 (
        .i_clk     (clk),
        .i_rst_n   (rst_n),
        .i_valid   (v1),
        .i_data    (d1),
        .i_last    (l1),
        .o_ready   (r1),
        .o_valid   (ov1),
        .o_data    (od1),
        .o_last    (ol1),
        .i_ready   (rdy1),
        .o_grant   (g1),
        .o_busy    (busy1),
        .o_pkt_cnt (cnt1)
    );

    // ---------------- bookkeeping ----------------
    int n_checks = 0;
    int n_errors = 0;
    bit chk_en   = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- requester sources ----------------
    int src_left[N];
    int src_len[N];
    int src_b[N];
    bit src_hold[N];

    function automatic logic [31:0] beat_data(input int k, input int b, input int len);
        if (b == len - 1) return 32'hB0 + 32'(k);
        return 32'hA0 + 32'(k) + 32'(b << 8);
    endfunction

    task automatic start_src(input int k, input int len, input int npk);
        src_len[k]  = len;
        src_b[k]    = 0;
        src_left[k] = npk;
    endtask

    task automatic drive_sources();
        for (int k = 0; k < N; k++) begin
            req_valid[k]             = (src_left[k] > 0) && !src_hold[k];
            req_data[k*DW +: DW]     = beat_data(k, src_b[k], src_len[k]);
            req_last[k]              = (src_b[k] == src_len[k] - 1);
        end
    endtask

    function automatic bit src_pending();
        for (int k = 0; k < N; k++) if (src_left[k] > 0) return 1'b1;
        return 1'b0;
    endfunction

    // One clock cycle: sample handshakes mid-cycle, then advance the sources
    // just after the rising edge.
    task automatic tick();
        logic [N-1:0] h;
        @(negedge clk);
        h = req_valid & req_ready;
        @(posedge clk);
        #1;
        for (int k = 0; k < N; k++) begin
            if (h[k]) begin
                src_b[k]++;
                if (src_b[k] == src_len[k]) begin
                    src_b[k] = 0;
                    src_left[k]--;
                end
            end
        end
        drive_sources();
    endtask

    // ---------------- behavioural model ----------------
    // The owner is -1 when no requester owns the sink.
    int            m_owner = -1;
    int            m_ptr   = 0;
    logic [CW-1:0] m_cnt   = '0;

    always @(posedge clk) begin : model_blk
        int j;
        if (!rst_n) begin
            m_owner = -1;
            m_ptr   = 0;
            m_cnt   = '0;
        end else if (m_owner < 0) begin
            for (int i = 0; i < N; i++) begin
                j = (m_ptr + i) % N;
                if (req_valid[j]) begin
                    m_owner = j;
                    break;
                end
            end
        end else if (req_valid[m_owner] && snk_ready && req_last[m_owner]) begin
            m_ptr   = (m_owner + 1) % N;
            m_cnt   = m_cnt + 1'b1;
            m_owner = -1;
        end
    end

    // ---------------- per-cycle compare against the model ----------------
    always @(negedge clk) begin
        logic [N-1:0] eg, er;
        logic         ev, el;
        logic [31:0]  ed;
        if (chk_en) begin
            eg = '0; er = '0; ev = 1'b0; el = 1'b0; ed = '0;
            if (m_owner >= 0) begin
                eg[m_owner] = 1'b1;
                er[m_owner] = snk_ready;
                ev          = req_valid[m_owner];
                el          = req_last[m_owner];
                ed          = req_data[m_owner*DW +: DW];
            end
            chk("grant", 32'(grant), 32'(eg));
            chk("busy", 32'(busy), 32'(m_owner >= 0));
            chk("ready", 32'(req_ready), 32'(er));
            chk("sink_valid", 32'(snk_valid), 32'(ev));
            chk("sink_last", 32'(snk_last), 32'(el));
            chk("sink_data", snk_data, ed);
            chk("pkt_cnt", 32'(pkt_cnt), 32'(m_cnt));
            chk("grant_onehot0", 32'($onehot0(grant)), 32'd1);
            chk("busy_eq_or_grant", 32'(busy), 32'(|grant));
            chk("ready_onehot0", 32'($onehot0(req_ready)), 32'd1);
            chk("valid_implies_busy", 32'(!snk_valid || busy), 32'd1);
        end
    end

    // ---------------- scoreboard of sink beats ----------------
    logic [DW-1:0] exp_q[$];

    always @(negedge clk) begin
        if (chk_en && rst_n && snk_valid && snk_ready) begin
            if (exp_q.size() == 0) begin
                n_checks++;
                n_errors++;
                $display("FAIL sink_beat: got unexpected beat %0h, required none", snk_data);
            end else begin
                chk("sink_beat", snk_data, exp_q.pop_front());
            end
        end
    end

    task automatic drain(input string name, input int bound);
        int n;
        n = 0;
        while ((exp_q.size() != 0 || src_pending()) && n < bound) begin
            tick();
            n++;
        end
        chk({name, "_drain_in_time"}, 32'(n < bound), 32'd1);
        chk({name, "_queue_empty"}, 32'(exp_q.size()), 32'd0);
    endtask

    // ---------------- watchdog ----------------
    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- directed scenarios ----------------
    initial begin
        logic pat[5];
        rst_n = 1'b0; req_valid = '0; req_data = '0; req_last = '0; snk_ready = 1'b1;
        v1 = 1'b0; d1 = '0; l1 = 1'b0; rdy1 = 1'b1;
        for (int k = 0; k < N; k++) begin
            src_left[k] = 0; src_len[k] = 0; src_b[k] = 0; src_hold[k] = 1'b0;
        end
        repeat (2) @(posedge clk);
        #1;
        rst_n  = 1'b1;
        chk_en = 1'b1;

        // Reset state, idle inputs for 5 cycles.
        for (int t = 0; t < 5; t++) begin
            tick();
            chk("idle_grant", 32'(grant), 32'd0);
            chk("idle_valid", 32'(snk_valid), 32'd0);
            chk("idle_ready", 32'(req_ready), 32'd0);
            chk("idle_cnt", 32'(pkt_cnt), 32'd0);
        end

        // Fairness: all four valid, 2-beat packets, two rotations.
        for (int k = 0; k < N; k++) start_src(k, 2, 2);
        for (int r = 0; r < 2; r++) begin
            for (int k = 0; k < N; k++) begin
                exp_q.push_back(32'hA0 + 32'(k));
                exp_q.push_back(32'hB0 + 32'(k));
            end
        end
        drive_sources();
        for (int t = 1; t <= 12; t++) begin
            tick();
            chk("rr_grant", 32'(grant), (t % 3 == 0) ? 32'd0 : (32'd1 << ((t - 1) / 3)));
            chk("rr_cnt", 32'(pkt_cnt), 32'(t / 3));
        end
        drain("rr", 60);
        chk("rr_cnt_final", 32'(pkt_cnt), 32'd8);

        // Requester 2, 3-beat packet, sink ready toggling 1,0,1,0,1.
        start_src(2, 3, 1);
        exp_q.push_back(32'hA2);
        exp_q.push_back(32'h1A2);
        exp_q.push_back(32'hB2);
        drive_sources();
        tick();
        pat = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
        for (int i = 0; i < 5; i++) begin
            snk_ready = pat[i];
            #1;
            chk("stall_grant", 32'(grant), 32'b0100);
            chk("stall_others_ready", 32'(req_ready & 4'b1011), 32'd0);
            chk("stall_owner_ready", 32'(req_ready[2]), 32'(pat[i]));
            tick();
        end
        snk_ready = 1'b1;
        chk("stall_grant_after", 32'(grant), 32'd0);
        chk("stall_cnt", 32'(pkt_cnt), 32'd9);
        chk("stall_queue_empty", 32'(exp_q.size()), 32'd0);

        // Requester 1 locked, pauses 3 cycles while requester 3 waits.
        start_src(1, 3, 1);
        drive_sources();
        tick();
        chk("pause_grant1", 32'(grant), 32'b0010);
        start_src(3, 1, 1);
        exp_q.push_back(32'hA1);
        exp_q.push_back(32'h1A1);
        exp_q.push_back(32'hB1);
        exp_q.push_back(32'hB3);
        drive_sources();
        tick();
        src_hold[1] = 1'b1;
        drive_sources();
        for (int i = 0; i < 3; i++) begin
            #1;
            chk("pause_valid", 32'(snk_valid), 32'd0);
            chk("pause_grant", 32'(grant), 32'b0010);
            chk("pause_r3_ready", 32'(req_ready[3]), 32'd0);
            tick();
        end
        src_hold[1] = 1'b0;
        drive_sources();
        tick();
        chk("pause_grant_kept", 32'(grant), 32'b0010);
        tick();
        chk("pause_end_idle", 32'(grant), 32'd0);
        chk("pause_end_cnt", 32'(pkt_cnt), 32'd10);
        tick();
        chk("pause_next_grant", 32'(grant), 32'b1000);
        tick();
        chk("pause_r3_done", 32'(pkt_cnt), 32'd11);
        chk("pause_queue_empty", 32'(exp_q.size()), 32'd0);

        // Reset during beat 2 of requester 0's 4-beat packet.
        start_src(0, 4, 1);
        start_src(1, 1, 1);
        exp_q.push_back(32'hA0);
        drive_sources();
        tick();
        chk("rst_grant0", 32'(grant), 32'b0001);
        tick();
        snk_ready = 1'b0;
        rst_n     = 1'b0;
        #1;
        chk("rst_beat2_data", snk_data, 32'h1A0);
        tick();
        rst_n     = 1'b1;
        snk_ready = 1'b1;
        chk("rst_grant", 32'(grant), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_cnt", 32'(pkt_cnt), 32'd0);
        chk("rst_valid", 32'(snk_valid), 32'd0);
        start_src(0, 1, 1);
        exp_q.push_back(32'hB0);
        exp_q.push_back(32'hB1);
        drive_sources();
        tick();
        chk("rst_search_from0", 32'(grant), 32'b0001);
        drain("rst", 20);
        chk("rst_cnt_after", 32'(pkt_cnt), 32'd2);

        // Single requester, 3-bit counter: gating and wrap.
        v1 = 1'b1; l1 = 1'b1; rdy1 = 1'b1;
        for (int p = 0; p < 9; p++) begin
            d1 = 32'h100 + 32'(p);
            #1;
            chk("n1_idle_grant", 32'(g1), 32'd0);
            chk("n1_idle_valid", 32'(ov1), 32'd0);
            @(posedge clk);
            #1;
            chk("n1_grant", 32'(g1), 32'd1);
            chk("n1_valid", 32'(ov1), 32'd1);
            chk("n1_ready", 32'(r1), 32'd1);
            chk("n1_data", od1, 32'h100 + 32'(p));
            @(posedge clk);
            #1;
            chk("n1_cnt", 32'(cnt1), 32'((p + 1) % 8));
            if (p == 7) chk("n1_wrap", 32'(cnt1), 32'd0);
        end
        v1 = 1'b0;
        @(posedge clk);
        #1;

        chk("final_queue_empty", 32'(exp_q.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/rr_stream_arbiter.md
Name: rr_stream_arbiter

Overview:
- Round-robin arbiter that shares one downstream stream sink (output/log channel) between N_REQ requester streams.
- Uses valid/ready handshakes with packet locking: once a requester is granted, it owns the sink until it completes a beat with last=1.
- Sits between test/stimulus sources and a single shared consumer.
- Also keeps a count of completed packets.

Parameters:
- N_REQ, 4, number of requesters; legal range 1..16.
- DATA_W, 32, data width per beat.
- CNT_W, 16, width of the completed-packet counter.

Ports:
- i_clk  input  1  clock, rising edge.
- i_rst_n  input  1  synchronous reset, active-low.
- i_valid  input  N_REQ  per-requester beat valid.
- i_data  input  N_REQ*DATA_W  per-requester data; requester k occupies bits [k*DATA_W +: DATA_W].
- i_last  input  N_REQ  per-requester last-beat-of-packet flag.
- o_ready  output  N_REQ  per-requester ready.
- o_valid  output  1  sink valid.
- o_data  output  DATA_W  sink data.
- o_last  output  1  sink last.
- i_ready  input  1  sink ready.
- o_grant  output  N_REQ  one-hot current owner; all zero when idle.
- o_busy  output  1  high while in LOCKED.
- o_pkt_cnt  output  CNT_W  number of completed packets.

Behaviour:
- Reset (i_rst_n low at a rising edge) is synchronous and has priority over everything:
  - state=IDLE, rr_ptr=0, o_grant=0, o_busy=0, o_pkt_cnt=0.
  - Outputs o_valid, o_ready, o_last are 0 and o_data is 0 while idle.
- Reset mid-packet aborts the packet immediately:
  - the partial packet is not counted;
  - arbitration restarts at index 0.
- State IDLE:
  - Outputs are all deasserted.
  - If any i_valid is set at a clock edge, select the first k with i_valid[k]=1, searching rr_ptr, rr_ptr+1, … modulo N_REQ.
  - Register o_grant=onehot(k), go to LOCKED.
  - No beat is transferred in the arbitration cycle.
- State LOCKED, owner g. The datapath is combinational pass-through:
  - o_valid=i_valid[g], o_data=i_data[g], o_last=i_last[g].
  - o_ready[g]=i_ready; o_ready of every other requester is 0.
- A beat transfers when o_valid and i_ready are both 1 at a clock edge.
- Transfer with o_last=1:
  - state goes to IDLE, o_grant=0;
  - rr_ptr=(g+1) mod N_REQ;
  - o_pkt_cnt increments, wrapping modulo 2^CNT_W.
- Transfer with o_last=0: remain LOCKED.
- Owner deasserting i_valid mid-packet: remain LOCKED with o_valid=0. There is no timeout and no preemption, even when other requesters are waiting.
- Latency:
  - A request seen in IDLE at edge t means the first beat is presented during cycle t+1, i.e. one bubble cycle.
  - Exactly one idle cycle separates the end of one packet from the next grant.
  - The maximum sustained rate within a packet is one beat per cycle.
- Fairness: with all requesters continuously valid, grants rotate 0,1,…,N_REQ-1,0,…
- Single-beat packet (i_last=1 on the first beat): LOCKED lasts exactly one cycle if i_ready=1.
- i_ready low holds the beat; the requester keeps data stable per the normal valid/ready rules.
- N_REQ=1: rr_ptr stays 0; the arbiter behaves as a packet gate with one idle cycle between packets.
- Non-owner i_valid/i_data/i_last changes never affect the outputs while LOCKED.
- The arbitration search treats i_valid only at the decision edge. A request dropped before that edge is ignored.
- Assertions the bench must check every cycle:
  - o_grant is one-hot or zero.
  - o_busy == |o_grant.
  - popcount(o_ready) ≤ 1.
  - o_valid implies o_busy.

Test Plan:
- Reset, then hold all i_valid=0 for 5 cycles -> o_grant=0, o_valid=0, o_ready=0, o_pkt_cnt=0 throughout.
- N_REQ=4, all four requesters continuously valid, each sending 2-beat packets (data 0xA0+k, then 0xB0+k with last=1), i_ready=1:
  - sink sequence is A0,B0,A1,B1,A2,B2,A3,B3,A0…;
  - one idle cycle between packets;
  - o_pkt_cnt=4 after the first rotation.
- Requester 2 sends a 3-beat packet; i_ready toggles 1,0,1,0,1 -> beats are accepted only on i_ready=1 cycles; o_grant stays 4'b0100 until the last beat; o_ready[0,1,3]=0 throughout.
- Requester 1 locked, drops i_valid for 3 cycles mid-packet while requester 3 is valid -> o_valid=0 for those cycles; grant stays 1; requester 3 is granted only after requester 1's last beat.
- Assert i_rst_n=0 for one cycle during beat 2 of requester 0's 4-beat packet:
  - next cycle state is IDLE and o_pkt_cnt=0;
  - requester 1 (if valid) is not favoured, because the search restarts at index 0.
- Preload o_pkt_cnt via 65535 one-beat packets with CNT_W=16, then one more packet -> o_pkt_cnt wraps to 0.
